ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver, successor to the keyboard interface. It adds the following over that block:
- input synchronisation and a glitch filter on ps2_clk
- a frame watchdog that discards partial frames
- separate sticky parity and framing error flags
- a drop-on-full FIFO of configurable depth, with a level output

It sits between the PS/2 pins and the keyboard/console logic. The consumer interface is unchanged: nextdata_n and a data/ready pair.

---
 rtl/ps2_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with synchronised, glitch-filtered clock, frame watchdog,
// sticky error flags and a drop-on-full first-word-fall-through byte FIFO.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2     = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  nextdata_n,
    input  logic                  clear_err,
    output logic [7:0]            data,
    output logic                  ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam int                  WD_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]          FILT_MAX   = 4'(FILTER_LEN - 1);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic                  clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic                  filt_q, filt_d, filt_prev_q;
    logic [3:0]            filt_cnt_q, filt_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ready_q, ready_d;
    logic                  ovf_q, ovf_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic [7:0]            mem_q [DEPTH];

    logic strobe, push, push_ok, pop, full;
    logic par_bad, stop_bad, par_set, frm_set, ovf_set;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            data_s1_q   <= 1'b1;
            data_s2_q   <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            wd_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_q     <= 1'b0;
            ovf_q       <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            data_s1_q   <= ps2_data;
            data_s2_q   <= data_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            wd_q        <= wd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            ovf_q       <= ovf_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
        end
    end

    // Storage is deliberately not reset; data is only meaningful while ready is high.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // A level change is accepted only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
    end

    assign strobe = filt_prev_q & ~filt_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        wd_d      = wd_q;
        push      = 1'b0;
        par_bad   = 1'b0;
        stop_bad  = 1'b0;
        par_set   = 1'b0;
        frm_set   = 1'b0;
        if (strobe) begin
            wd_d = '0;
            if (bit_cnt_q == 4'd0) begin
                if (data_s2_q) begin
                    frm_set = 1'b1;
                end else begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {data_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                par_bit_d = data_s2_q;
                bit_cnt_d = 4'd10;
            end else begin
                bit_cnt_d = 4'd0;
                par_bad   = ~(^{shift_q, par_bit_q});
                stop_bad  = ~data_s2_q;
                par_set   = par_bad;
                frm_set   = stop_bad;
                push      = ~par_bad & ~stop_bad;
            end
        end else if (bit_cnt_q != 4'd0) begin
            // Watchdog only runs mid-frame; expiry abandons the partial frame.
            if (wd_q == WD_LAST) begin
                bit_cnt_d = 4'd0;
                wd_d      = '0;
                frm_set   = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            wd_d = '0;
        end
    end

    assign pop     = ~nextdata_n & (level_q != '0);
    assign full    = (level_q == FULL_LEVEL);
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        ready_d   = (level_d != '0);
        ovf_d     = (ovf_q & ~clear_err) | ovf_set;
        par_err_d = (par_err_q & ~clear_err) | par_set;
        frm_err_d = (frm_err_q & ~clear_err) | frm_set;
    end

    assign data       = mem_q[rd_ptr_q];
    assign ready      = ready_q;
    assign level      = level_q;
    assign overflow   = ovf_q;
    assign parity_err = par_err_q;
    assign frame_err  = frm_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table-driven frames plus hand-written FIFO,
// watchdog, glitch and reset sequences, with a byte scoreboard.
module tb_ps2_rx_fifo;

    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 300;
    localparam int HALF       = 20;
    localparam int GAP        = 20;

    logic                clk = 1'b0;
    logic                clrn = 1'b0;
    logic                ps2_clk = 1'b1;
    logic                ps2_data = 1'b1;
    logic                nextdata_n = 1'b1;
    logic                clear_err = 1'b0;
    logic [7:0]          data;
    logic                ready;
    logic [DEPTH_LOG2:0] level;
    logic                overflow, parity_err, frame_err;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] byte_val;
        bit         clr_before;
        bit         par_flip;
        bit         stop_val;
        bit         exp_push;
        bit         exp_par;
        bit         exp_frm;
    } vec_t;

    vec_t vecs[6];

    ps2_rx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .clrn(clrn),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .nextdata_n(nextdata_n),
        .clear_err(clear_err),
        .data(data),
        .ready(ready),
        .level(level),
        .overflow(overflow),
        .parity_err(parity_err),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL sim_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    // Pops the scoreboard head, compares it with the FIFO head, then issues one pop cycle.
    task automatic pop_check(input string name);
        logic [7:0] exp_byte;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s actual=scoreboard_empty expected=entry", name);
            return;
        end
        exp_byte = sb.pop_front();
        checkOutput({name, "_ready"}, 32'(ready), 32'd1);
        checkOutput({name, "_data"}, 32'(data), 32'(exp_byte));
        nextdata_n = 1'b0;
        tick();
        nextdata_n = 1'b1;
    endtask

    // Device drives data while clock is high; host samples on the falling edge.
    task automatic send_bit(input bit b, input bit glitch, input bit pop_at_push);
        ps2_data = b;
        if (glitch) begin
            repeat (8) tick();
            ps2_clk = 1'b0;
            repeat (2) tick();
            ps2_clk = 1'b1;
            repeat (HALF - 10) tick();
        end else begin
            repeat (HALF) tick();
        end
        ps2_clk = 1'b0;
        if (pop_at_push) begin
            // Push lands on the 7th edge after the falling edge (2 sync + FILTER_LEN + strobe).
            repeat (6) tick();
            checkOutput("pp_level_before", 32'(level), 32'(DEPTH));
            checkOutput("pp_head", 32'(data), 32'(sb.pop_front()));
            nextdata_n = 1'b0;
            tick();
            nextdata_n = 1'b1;
            checkOutput("pp_level_after", 32'(level), 32'(DEPTH));
            repeat (HALF - 7) tick();
        end else begin
            repeat (HALF) tick();
        end
        ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit par_flip, input bit stop_val,
                                 input bit glitch, input bit pop_at_push);
        logic par;
        par = ~(^d) ^ par_flip;
        send_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], glitch, 1'b0);
        end
        send_bit(par, glitch, 1'b0);
        send_bit(stop_val, glitch, pop_at_push);
        ps2_data = 1'b1;
        repeat (GAP) tick();
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) tick();
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_parity", 32'(parity_err), 32'd0);
        checkOutput("rst_frame", 32'(frame_err), 32'd0);
        clrn = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr_before) pulse_clear();
            if (vecs[i].exp_push) sb.push_back(vecs[i].byte_val);
            applyStimulus(vecs[i].byte_val, vecs[i].par_flip, vecs[i].stop_val, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d_level", i), 32'(level), 32'(sb.size()));
            checkOutput($sformatf("vec%0d_parity", i), 32'(parity_err), 32'(vecs[i].exp_par));
            checkOutput($sformatf("vec%0d_frame", i), 32'(frame_err), 32'(vecs[i].exp_frm));
            if (vecs[i].exp_push) pop_check($sformatf("vec%0d_pop", i));
            checkOutput($sformatf("vec%0d_ready_after", i), 32'(ready), 32'd0);
        end
        pulse_clear();
        checkOutput("clear_parity", 32'(parity_err), 32'd0);
        checkOutput("clear_frame", 32'(frame_err), 32'd0);

        // Overflow: nine frames with no reads, the ninth must be dropped.
        for (int i = 1; i <= DEPTH + 1; i++) begin
            if (sb.size() < DEPTH) sb.push_back(8'(i));
            applyStimulus(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("ovf_level", 32'(level), 32'(DEPTH));
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i));
        checkOutput("drain_ready", 32'(ready), 32'd0);
        checkOutput("drain_level", 32'(level), 32'd0);
        nextdata_n = 1'b0;
        tick();
        nextdata_n = 1'b1;
        checkOutput("pop_empty_level", 32'(level), 32'd0);
        pulse_clear();
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Watchdog: five bits then silence.
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        repeat (TIMEOUT - 50) tick();
        checkOutput("wd_not_yet", 32'(frame_err), 32'd0);
        repeat (52) tick();
        checkOutput("wd_frame", 32'(frame_err), 32'd1);
        checkOutput("wd_level", 32'(level), 32'd0);
        sb.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_check("wd_next");
        pulse_clear();

        // Short glitches on ps2_clk must not create extra strobes.
        sb.push_back(8'h96);
        applyStimulus(8'h96, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("glitch_level", 32'(level), 32'd1);
        checkOutput("glitch_frame", 32'(frame_err), 32'd0);
        checkOutput("glitch_parity", 32'(parity_err), 32'd0);
        pop_check("glitch_pop");
        send_bit(1'b1, 1'b0, 1'b0);
        repeat (GAP) tick();
        checkOutput("badstart_frame", 32'(frame_err), 32'd1);
        checkOutput("badstart_level", 32'(level), 32'd0);
        pulse_clear();

        // Full FIFO with a pop in the push cycle: push accepted, no overflow.
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back(8'(8'h10 + i));
            applyStimulus(8'(8'h10 + i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("full_level", 32'(level), 32'(DEPTH));
        sb.push_back(8'h18);
        applyStimulus(8'h18, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("pp_level", 32'(level), 32'(DEPTH));
        checkOutput("pp_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("pp_drain%0d", i));
        checkOutput("pp_ready", 32'(ready), 32'd0);

        // Asynchronous reset mid-frame with data held and a flag set.
        applyStimulus(8'h44, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("prerst_level", 32'(level), 32'd1);
        checkOutput("prerst_parity", 32'(parity_err), 32'd1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        clrn = 1'b0;
        #2;
        checkOutput("arst_ready", 32'(ready), 32'd0);
        checkOutput("arst_level", 32'(level), 32'd0);
        checkOutput("arst_parity", 32'(parity_err), 32'd0);
        checkOutput("arst_frame", 32'(frame_err), 32'd0);
        checkOutput("arst_overflow", 32'(overflow), 32'd0);
        sb.delete();
        repeat (3) tick();
        clrn = 1'b1;
        ps2_data = 1'b1;
        repeat (GAP) tick();
        sb.push_back(8'h33);
        applyStimulus(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_level", 32'(level), 32'd1);
        checkOutput("post_rst_frame", 32'(frame_err), 32'd0);
        pop_check("post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
